// File: rtl/stage5_writeback_if.sv
// Memory-to-writeback stream: one beat per instruction leaving the memory stage.
// The writeback stage consumes it through the "in" modport.
interface Axis #(
    parameter int WIDTH = 32
);
    logic             tvalid;
    logic             tready;
    logic [WIDTH-1:0] data_from_memory;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] branch_target;
    logic [31:0]      decoded_instruction;

    modport in (
        input  tvalid,
        input  data_from_memory,
        input  alu_result,
        input  branch_target,
        input  decoded_instruction,
        output tready
    );

    modport out (
        output tvalid,
        output data_from_memory,
        output alu_result,
        output branch_target,
        output decoded_instruction,
        input  tready
    );
endinterface

// File: rtl/stage5_writeback.sv
// Writeback stage: picks the result source, extends load data, and holds one register-file write.
// It also keeps the instret/cycle counters. Defining WRITEBACK_TRACE_EN adds a retire trace port.
module stage5_writeback #(
    parameter int REGISTER_WIDTH = 32,
    parameter int COUNTER_WIDTH  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    Axis.in                           axis_memory_to_writeback,
    output logic                      rf_write_valid,
    input  logic                      rf_write_ready,
    output logic [4:0]                rf_write_address,
    output logic [REGISTER_WIDTH-1:0] rf_write_data,
    output logic [COUNTER_WIDTH-1:0]  instret,
    output logic [COUNTER_WIDTH-1:0]  cycle
`ifdef WRITEBACK_TRACE_EN
    ,
    output logic                      trace_valid,
    output logic [31:0]               trace_instruction,
    output logic [REGISTER_WIDTH-1:0] trace_data
`endif
);

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    logic [31:0]               instruction;
    logic [6:0]                opcode;
    logic [4:0]                rd;
    logic [2:0]                funct3;
    logic                      accept;
    logic                      writes_rd;
    logic [REGISTER_WIDTH-1:0] shifted;
    logic [REGISTER_WIDTH-1:0] load_value;
    logic [REGISTER_WIDTH-1:0] result;
    logic                      unused_fields;

    assign instruction = axis_memory_to_writeback.decoded_instruction;
    assign opcode      = instruction[6:0];
    assign rd          = instruction[11:7];
    assign funct3      = instruction[14:12];

    // One-entry output register: a new beat may enter whenever the held write leaves.
    assign axis_memory_to_writeback.tready = !rf_write_valid || rf_write_ready;
    assign accept = axis_memory_to_writeback.tvalid && axis_memory_to_writeback.tready;

    assign unused_fields = ^{axis_memory_to_writeback.branch_target, instruction[31:15]};

    always_comb begin
        writes_rd = 1'b0;
        case (opcode)
            OPCODE_OP, OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_LUI,
            OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR: writes_rd = 1'b1;
            default:                               writes_rd = 1'b0;
        endcase
    end

    // Misaligned accesses are not trapped; the shift simply leaves zeros in the upper lanes.
    always_comb begin
        shifted    = axis_memory_to_writeback.data_from_memory >>
                     {axis_memory_to_writeback.alu_result[1:0], 3'b000};
        load_value = shifted;
        case (funct3)
            FUNCT3_LB:  load_value = {{(REGISTER_WIDTH-8){shifted[7]}}, shifted[7:0]};
            FUNCT3_LBU: load_value = {{(REGISTER_WIDTH-8){1'b0}}, shifted[7:0]};
            FUNCT3_LH:  load_value = {{(REGISTER_WIDTH-16){shifted[15]}}, shifted[15:0]};
            FUNCT3_LHU: load_value = {{(REGISTER_WIDTH-16){1'b0}}, shifted[15:0]};
            FUNCT3_LW:  load_value = shifted;
            default:    load_value = shifted;
        endcase
        result = (opcode == OPCODE_LOAD) ? load_value : axis_memory_to_writeback.alu_result;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_write_valid   <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
            instret          <= '0;
            cycle            <= '0;
        end else begin
            cycle <= cycle + COUNTER_WIDTH'(1);
            if (accept) begin
                instret          <= instret + COUNTER_WIDTH'(1);
                rf_write_valid   <= writes_rd && (rd != 5'd0);
                rf_write_address <= rd;
                rf_write_data    <= result;
            end else if (rf_write_ready) begin
                rf_write_valid <= 1'b0;
            end
        end
    end

`ifdef WRITEBACK_TRACE_EN
    // Trace reports every retired beat, including those that never reach the register file.
    always_ff @(posedge clk) begin
        if (!rst) begin
            trace_valid       <= 1'b0;
            trace_instruction <= '0;
            trace_data        <= '0;
        end else begin
            trace_valid <= accept;
            if (accept) begin
                trace_instruction <= instruction;
                trace_data        <= result;
            end
        end
    end
`endif

endmodule
